// File: rtl/alu_pkg.sv
// Shared ALU definitions used by the sequential divider.
// Contents:
//   ALU_WIDTH   - native datapath width of the ALU
//   DIV0_QUOT   - quotient returned for a divide by zero (all ones)
//   div_state_e - divider FSM state encoding
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  localparam logic [ALU_WIDTH-1:0] DIV0_QUOT = {ALU_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    DIV_IDLE  = 2'd0,
    DIV_RUN   = 2'd1,
    DIV_FIXUP = 2'd2,
    DIV_ZERO  = 2'd3
  } div_state_e;

endpackage

// File: rtl/cla_subtract_stage.sv
// Unsigned subtractor a_i - b_i computed as a_i + ~b_i + 1 with 4-bit
// carry-lookahead groups. Groups are chained through their group
// generate/propagate terms.
// Ports:
//   a_i      in  W  minuend
//   b_i      in  W  subtrahend
//   diff_o   out W  a_i - b_i (mod 2**W)
//   borrow_o out 1  1 when a_i < b_i (unsigned)
module cla_subtract_stage #(
  parameter int W = 33
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] diff_o,
  output logic         borrow_o
);

  // Operands are zero-extended to a whole number of 4-bit groups; the
  // extension does not change the unsigned compare, so the final group
  // carry-out is still "a_i >= b_i".
  localparam int NG = (W + 3) / 4;
  localparam int PW = NG * 4;

  logic [PW-1:0] a_s;
  logic [PW-1:0] nb_s;
  logic [PW-1:0] g_s;
  logic [PW-1:0] p_s;
  logic [PW-1:0] x_s;
  logic [PW-1:0] c_s;
  logic [PW-1:0] sum_s;
  logic [NG:0]   gc_s;

  assign a_s  = PW'(a_i);
  assign nb_s = ~(PW'(b_i));
  assign g_s  = a_s & nb_s;
  assign p_s  = a_s | nb_s;
  assign x_s  = a_s ^ nb_s;

  // The +1 of the two's-complement subtract enters as the first carry-in.
  assign gc_s[0] = 1'b1;

  for (genvar gi = 0; gi < NG; gi++) begin : g_grp
    localparam int B = gi * 4;
    logic cin_s;
    logic gg_s;
    logic gp_s;

    assign cin_s    = gc_s[gi];
    assign c_s[B]   = cin_s;
    assign c_s[B+1] = g_s[B] | (p_s[B] & cin_s);
    assign c_s[B+2] = g_s[B+1] | (p_s[B+1] & g_s[B]) | (p_s[B+1] & p_s[B] & cin_s);
    assign c_s[B+3] = g_s[B+2] | (p_s[B+2] & g_s[B+1]) | (p_s[B+2] & p_s[B+1] & g_s[B])
                    | (p_s[B+2] & p_s[B+1] & p_s[B] & cin_s);

    assign gg_s = g_s[B+3] | (p_s[B+3] & g_s[B+2]) | (p_s[B+3] & p_s[B+2] & g_s[B+1])
                | (p_s[B+3] & p_s[B+2] & p_s[B+1] & g_s[B]);
    assign gp_s = p_s[B+3] & p_s[B+2] & p_s[B+1] & p_s[B];

    assign gc_s[gi+1] = gg_s | (gp_s & cin_s);
  end

  assign sum_s    = x_s ^ c_s;
  assign diff_o   = sum_s[W-1:0];
  assign borrow_o = ~gc_s[NG];

  if (PW > W) begin : g_pad
    logic unused_pad_s;
    assign unused_pad_s = ^sum_s[PW-1:W];
  end

endmodule

// File: rtl/seq_divider32.sv
// Multi-cycle restoring divider (signed or unsigned), one quotient bit per
// clock, with a start/done handshake.
// Ports:
//   clk          in  1      rising-edge clock
//   rst_n        in  1      asynchronous active-low reset
//   start        in  1      request, sampled only in IDLE
//   signed_op    in  1      1 = two's-complement operands
//   dividend     in  WIDTH  numerator, latched on accept
//   divisor      in  WIDTH  denominator, latched on accept
//   busy         out 1      high from the cycle after accept until done
//   done         out 1      one-cycle result pulse
//   quotient     out WIDTH  held until the next result
//   remainder    out WIDTH  sign follows the dividend
//   div_by_zero  out 1      set with done for divisor == 0, cleared on accept
module seq_divider32
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   r_q, r_d;          // partial remainder, MSB holds the borrow headroom
  logic [WIDTH-1:0] q_q, q_d;          // dividend magnitude shifting into the quotient
  logic [WIDTH-1:0] dvsr_q, dvsr_d;    // divisor magnitude
  logic             neg_quot_q, neg_quot_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  logic             div_zero_s;
  logic [WIDTH:0]   shift_s;
  logic [WIDTH:0]   trial_s;
  logic             trial_borrow_s;
  logic [WIDTH-1:0] neg_a_in_s, neg_a_out_s;
  logic [WIDTH-1:0] neg_b_in_s, neg_b_out_s;
  logic             neg_a_borrow_s, neg_b_borrow_s;
  logic [WIDTH-1:0] dnd_mag_s, dvs_mag_s;
  logic             unused_s;

  assign div_zero_s = (divisor == {WIDTH{1'b0}});

  // Restoring step: shift {R,Q} left and try R - |divisor|.
  assign shift_s = {r_q[WIDTH-1:0], q_q[WIDTH-1]};

  cla_subtract_stage #(.W(WIDTH + 1)) u_step_sub (
    .a_i      (shift_s),
    .b_i      ({1'b0, dvsr_q}),
    .diff_o   (trial_s),
    .borrow_o (trial_borrow_s)
  );

  // The two negators serve the operand magnitudes in IDLE and the sign
  // fixup of quotient/remainder in FIXUP, so both phases share them.
  always_comb begin
    if (state_q == DIV_FIXUP) begin
      neg_a_in_s = q_q;
      neg_b_in_s = r_q[WIDTH-1:0];
    end else begin
      neg_a_in_s = dividend;
      neg_b_in_s = divisor;
    end
  end

  cla_subtract_stage #(.W(WIDTH)) u_neg_a (
    .a_i      ({WIDTH{1'b0}}),
    .b_i      (neg_a_in_s),
    .diff_o   (neg_a_out_s),
    .borrow_o (neg_a_borrow_s)
  );

  cla_subtract_stage #(.W(WIDTH)) u_neg_b (
    .a_i      ({WIDTH{1'b0}}),
    .b_i      (neg_b_in_s),
    .diff_o   (neg_b_out_s),
    .borrow_o (neg_b_borrow_s)
  );

  // Operand magnitudes as seen on the accepting cycle.
  always_comb begin
    if (signed_op && dividend[WIDTH-1]) begin
      dnd_mag_s = neg_a_out_s;
    end else begin
      dnd_mag_s = dividend;
    end
    if (signed_op && divisor[WIDTH-1]) begin
      dvs_mag_s = neg_b_out_s;
    end else begin
      dvs_mag_s = divisor;
    end
  end

  // R never exceeds the divisor after a step, so its top bit is only read
  // through the subtractor; the negator borrows carry no information.
  assign unused_s = ^{r_q[WIDTH], neg_a_borrow_s, neg_b_borrow_s};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DIV_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      DIV_IDLE: begin
        if (start) begin
          if (div_zero_s) begin
            state_d = DIV_ZERO;
          end else begin
            state_d = DIV_RUN;
          end
        end else begin
          state_d = DIV_IDLE;
        end
      end
      DIV_RUN: begin
        if (cnt_q == {CNT_W{1'b0}}) begin
          state_d = DIV_FIXUP;
        end else begin
          state_d = DIV_RUN;
        end
      end
      DIV_FIXUP: state_d = DIV_IDLE;
      DIV_ZERO:  state_d = DIV_IDLE;
      default:   state_d = DIV_IDLE;
    endcase
  end

  // Datapath and output next values per state.
  always_comb begin
    cnt_d      = cnt_q;
    r_d        = r_q;
    q_d        = q_q;
    dvsr_d     = dvsr_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    dbz_d      = dbz_q;
    case (state_q)
      DIV_IDLE: begin
        if (start) begin
          cnt_d      = CNT_W'(WIDTH - 1);
          r_d        = {(WIDTH + 1){1'b0}};
          neg_quot_d = signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          neg_rem_d  = signed_op & dividend[WIDTH-1];
          busy_d     = 1'b1;
          dbz_d      = 1'b0;
          // A zero divisor keeps the raw dividend for the remainder output.
          if (div_zero_s) begin
            q_d    = dividend;
            dvsr_d = divisor;
          end else begin
            q_d    = dnd_mag_s;
            dvsr_d = dvs_mag_s;
          end
        end else begin
          busy_d = 1'b0;
        end
      end
      DIV_RUN: begin
        if (trial_borrow_s) begin
          r_d = shift_s;
          q_d = {q_q[WIDTH-2:0], 1'b0};
        end else begin
          r_d = trial_s;
          q_d = {q_q[WIDTH-2:0], 1'b1};
        end
        if (cnt_q != {CNT_W{1'b0}}) begin
          cnt_d = cnt_q - {{(CNT_W - 1){1'b0}}, 1'b1};
        end else begin
          cnt_d = cnt_q;
        end
      end
      DIV_FIXUP: begin
        if (neg_quot_q) begin
          quot_d = neg_a_out_s;
        end else begin
          quot_d = q_q;
        end
        if (neg_rem_q) begin
          rem_d = neg_b_out_s;
        end else begin
          rem_d = r_q[WIDTH-1:0];
        end
        done_d = 1'b1;
        busy_d = 1'b0;
      end
      DIV_ZERO: begin
        quot_d = WIDTH'(DIV0_QUOT);
        rem_d  = q_q;
        dbz_d  = 1'b1;
        done_d = 1'b1;
        busy_d = 1'b0;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= {CNT_W{1'b0}};
      r_q        <= {(WIDTH + 1){1'b0}};
      q_q        <= {WIDTH{1'b0}};
      dvsr_q     <= {WIDTH{1'b0}};
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      quot_q     <= {WIDTH{1'b0}};
      rem_q      <= {WIDTH{1'b0}};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      r_q        <= r_d;
      q_q        <= q_d;
      dvsr_q     <= dvsr_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      dbz_q      <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider32.sv
// Self-checking bench for seq_divider32: directed scenarios plus randomized
// operations checked against an arithmetic reference model.
module tb_seq_divider32;

  localparam int W = 32;
  localparam int MAX_WAIT = 60;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         signed_op;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int vectors     = 0;
  int miscompares = 0;

  seq_divider32 #(.WIDTH(W), .CNT_W(6)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .signed_op   (signed_op),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain 64-bit integer division (truncating toward zero).
  function automatic void ref_div(input logic sop, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r, output logic dz);
    longint sa, sb, qq, rr;
    if (b == 32'd0) begin
      q  = 32'hFFFF_FFFF;
      r  = a;
      dz = 1'b1;
    end else begin
      if (sop) begin
        sa = $signed(a);
        sb = $signed(b);
      end else begin
        sa = {32'd0, a};
        sb = {32'd0, b};
      end
      qq = sa / sb;
      rr = sa % sb;
      q  = qq[31:0];
      r  = rr[31:0];
      dz = 1'b0;
    end
  endfunction

  // Issues one operation starting #1 after a clock edge with the DUT idle.
  // edges = number of clock edges after the accept edge until done is seen.
  task automatic do_op(input logic sop, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] q, output logic [W-1:0] r, output logic dz,
                       output int edges, output int busy_cnt, output logic busy_at_done);
    start = 1'b1; signed_op = sop; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0;
    edges = -1;
    busy_cnt = 0;
    busy_at_done = 1'b1;
    if (busy === 1'b1) busy_cnt++;
    for (int k = 1; k <= MAX_WAIT; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        edges = k;
        busy_at_done = busy;
        break;
      end
      if (busy === 1'b1) busy_cnt++;
    end
    q = quotient; r = remainder; dz = div_by_zero;
  endtask

  task automatic test_reset();
    start = 1'b0; signed_op = 1'b0; dividend = 32'd0; divisor = 32'd0;
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({busy, done, div_by_zero, quotient, remainder} !== 67'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got b=%b d=%b z=%b q=%h r=%h expected all zero",
               busy, done, div_by_zero, quotient, remainder);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_unsigned_basic();
    logic [W-1:0] q, r; logic dz, bad; int e, bc;
    do_op(1'b0, 32'd100, 32'd7, q, r, dz, e, bc, bad);
    vectors++;
    if (e !== 33) begin miscompares++; $display("FAIL u100_7_latency: got %0d expected 33", e); end
    vectors++;
    if (bc !== 33) begin miscompares++; $display("FAIL u100_7_busy_cycles: got %0d expected 33", bc); end
    vectors++;
    if (bad !== 1'b0) begin miscompares++; $display("FAIL u100_7_busy_at_done: got %b expected 0", bad); end
    vectors++;
    if ({q, r, dz} !== {32'd14, 32'd2, 1'b0}) begin
      miscompares++;
      $display("FAIL u100_7_result: got q=%h r=%h z=%b expected q=0000000e r=00000002 z=0", q, r, dz);
    end
    @(posedge clk); #1;
    vectors++;
    if ({done, quotient, remainder} !== {1'b0, 32'd14, 32'd2}) begin
      miscompares++;
      $display("FAIL done_pulse_hold: got d=%b q=%h r=%h expected d=0 q=0000000e r=00000002",
               done, quotient, remainder);
    end
  endtask

  task automatic test_signed_basic();
    logic [W-1:0] q, r; logic dz, bad; int e, bc;
    do_op(1'b1, 32'hFFFF_FFF9, 32'd2, q, r, dz, e, bc, bad);
    vectors++;
    if ({q, r, dz} !== {32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0}) begin
      miscompares++;
      $display("FAIL s_m7_2: got q=%h r=%h z=%b expected q=fffffffd r=ffffffff z=0", q, r, dz);
    end
  endtask

  task automatic test_div_by_zero();
    logic [W-1:0] q, r; logic dz, bad; int e, bc;
    do_op(1'b0, 32'hDEAD_BEEF, 32'd0, q, r, dz, e, bc, bad);
    vectors++;
    if (e !== 1) begin miscompares++; $display("FAIL dbz_latency: got %0d expected 1", e); end
    vectors++;
    if ({q, r, dz, bad} !== {32'hFFFF_FFFF, 32'hDEAD_BEEF, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL dbz_result: got q=%h r=%h z=%b busy=%b expected q=ffffffff r=deadbeef z=1 busy=0",
               q, r, dz, bad);
    end
  endtask

  task automatic test_overflow();
    logic [W-1:0] q, r; logic dz, bad; int e, bc;
    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, q, r, dz, e, bc, bad);
    vectors++;
    if ({q, r, dz} !== {32'h8000_0000, 32'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL s_min_m1: got q=%h r=%h z=%b expected q=80000000 r=00000000 z=0", q, r, dz);
    end
    do_op(1'b0, 32'hFFFF_FFFF, 32'h10, q, r, dz, e, bc, bad);
    vectors++;
    if ({q, r, dz} !== {32'h0FFF_FFFF, 32'h0000_000F, 1'b0}) begin
      miscompares++;
      $display("FAIL u_max_16: got q=%h r=%h z=%b expected q=0fffffff r=0000000f z=0", q, r, dz);
    end
  endtask

  task automatic test_start_ignored();
    logic [W-1:0] eq, er; logic edz; int e;
    logic [W-1:0] a0, b0;
    a0 = 32'd1000003; b0 = 32'd97;
    ref_div(1'b0, a0, b0, eq, er, edz);
    start = 1'b1; signed_op = 1'b0; dividend = a0; divisor = b0;
    @(posedge clk); #1;
    start = 1'b0;
    e = -1;
    for (int k = 1; k <= MAX_WAIT; k++) begin
      if (k == 10) begin
        start = 1'b1; signed_op = 1'b1; dividend = $urandom; divisor = 32'd3;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done === 1'b1) begin e = k; break; end
    end
    start = 1'b0;
    vectors++;
    if (e !== 33) begin miscompares++; $display("FAIL ignored_start_latency: got %0d expected 33", e); end
    vectors++;
    if ({quotient, remainder, div_by_zero} !== {eq, er, edz}) begin
      miscompares++;
      $display("FAIL ignored_start_result: got q=%h r=%h expected q=%h r=%h", quotient, remainder, eq, er);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] q, r, eq, er; logic dz, edz, bad; int e, bc;
    // A divide-by-zero followed immediately by a normal op also checks that
    // div_by_zero clears on the next accepted start.
    do_op(1'b0, 32'h1234_5678, 32'd0, q, r, dz, e, bc, bad);
    do_op(1'b1, 32'hFFFF_8000, 32'd300, q, r, dz, e, bc, bad);
    ref_div(1'b1, 32'hFFFF_8000, 32'd300, eq, er, edz);
    vectors++;
    if (e !== 33) begin miscompares++; $display("FAIL b2b_latency: got %0d expected 33", e); end
    vectors++;
    if ({q, r, dz} !== {eq, er, edz}) begin
      miscompares++;
      $display("FAIL b2b_result: got q=%h r=%h z=%b expected q=%h r=%h z=%b", q, r, dz, eq, er, edz);
    end
  endtask

  task automatic test_reset_abort();
    logic [W-1:0] q, r, eq, er; logic dz, edz, bad, seen; int e, bc;
    start = 1'b1; signed_op = 1'b0; dividend = 32'hDEAD_BEEF; divisor = 32'h1234;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, done, div_by_zero, quotient, remainder} !== 67'd0) begin
      miscompares++;
      $display("FAIL abort_outputs: got b=%b d=%b z=%b q=%h r=%h expected all zero",
               busy, done, div_by_zero, quotient, remainder);
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin miscompares++; $display("FAIL abort_no_done: got activity=%b expected 0", seen); end
    do_op(1'b1, 32'hF000_0001, 32'hFFFF_FFF3, q, r, dz, e, bc, bad);
    ref_div(1'b1, 32'hF000_0001, 32'hFFFF_FFF3, eq, er, edz);
    vectors++;
    if ({q, r, dz} !== {eq, er, edz} || e !== 33) begin
      miscompares++;
      $display("FAIL after_abort: got q=%h r=%h z=%b lat=%0d expected q=%h r=%h z=%b lat=33",
               q, r, dz, e, eq, er, edz);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, q, r, eq, er; logic sop, dz, edz, bad; int e, exp_e, bc;
    for (int n = 0; n < 40; n++) begin
      sop = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 6))
        0:       b = 32'd0;
        1:       b = 32'd1;
        2:       b = 32'hFFFF_FFFF;
        3:       b = 32'($urandom_range(2, 15));
        default: b = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       a = 32'd0;
        1:       a = 32'h8000_0000;
        default: a = $urandom;
      endcase
      ref_div(sop, a, b, eq, er, edz);
      exp_e = (b == 32'd0) ? 1 : 33;
      do_op(sop, a, b, q, r, dz, e, bc, bad);
      vectors++;
      if ({q, r, dz} !== {eq, er, edz}) begin
        miscompares++;
        $display("FAIL rand_result[%0d] s=%b %h/%h: got q=%h r=%h z=%b expected q=%h r=%h z=%b",
                 n, sop, a, b, q, r, dz, eq, er, edz);
      end
      vectors++;
      if (e !== exp_e) begin
        miscompares++;
        $display("FAIL rand_latency[%0d]: got %0d expected %0d", n, e, exp_e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned_basic();
    test_signed_basic();
    test_div_by_zero();
    test_overflow();
    test_start_ignored();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
